// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and
// the byte width common to the arbiter and the transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        START = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request strictly after the
// pointer, wrapping, so the pointer position itself has lowest priority.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int k;
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        k        = 0;
        // Walk from lowest to highest priority so the last hit wins.
        for (int i = N_REQ; i >= 1; i--) begin
            k = int'(i_ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (i_req[k]) begin
                o_any       = 1'b1;
                o_idx       = IDX_W'(k);
                o_onehot    = '0;
                o_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one uart_tx: one write strobe per
// byte, paced by the transmitter busy flag, with burst and stall release.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int MAX_BURST   = 16,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*DATA_BITS-1:0] i_req_data,
    input  logic [N_REQ-1:0]           i_req_last,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic [N_REQ-1:0]           o_grant,
    output logic                       o_tx_write,
    output logic [DATA_BITS-1:0]       o_tx_data,
    input  logic                       i_tx_busy,
    output logic                       o_burst_abort,
    output logic                       o_gap_timeout
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int GAP_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] PTR_RESET   = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 last_q, last_d;
    logic                 tx_write_q, tx_write_d;
    logic                 burst_abort_q, burst_abort_d;
    logic                 gap_timeout_q, gap_timeout_d;

    logic [N_REQ-1:0]     arb_onehot;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic [N_REQ-1:0]     owner;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req    (i_req_valid),
        .i_ptr    (ptr_q),
        .o_onehot (arb_onehot),
        .o_idx    (arb_idx),
        .o_any    (arb_any)
    );

    assign owner = N_REQ'(1) << idx_q;

    // Grant covers GRANT/START/DONE; only GRANT may accept a byte.
    assign o_grant       = (state_q == IDLE)  ? '0 : owner;
    assign o_req_ready   = (state_q == GRANT) ? owner : '0;
    assign o_tx_write    = tx_write_q;
    assign o_tx_data     = tx_data_q;
    assign o_burst_abort = burst_abort_q;
    assign o_gap_timeout = gap_timeout_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        gap_d         = gap_q;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        tx_write_d    = 1'b0;
        burst_abort_d = 1'b0;
        gap_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A byte may still be on the line after reset; wait it out.
                if (arb_any && !i_tx_busy) begin
                    idx_d   = arb_idx;
                    count_d = '0;
                    gap_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (i_req_valid[idx_q]) begin
                    tx_data_d  = i_req_data[idx_q*DATA_BITS +: DATA_BITS];
                    last_d     = i_req_last[idx_q];
                    count_d    = count_q + CNT_W'(1);
                    tx_write_d = 1'b1;
                    state_d    = START;
                end else if (gap_q == GAP_LAST) begin
                    gap_timeout_d = 1'b1;
                    ptr_d         = idx_q;
                    state_d       = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            START: begin
                if (i_tx_busy) state_d = DONE;
            end
            DONE: begin
                if (!i_tx_busy) begin
                    if (last_q) begin
                        ptr_d   = idx_q;
                        state_d = IDLE;
                    end else if (count_q == BURST_LIMIT) begin
                        burst_abort_d = 1'b1;
                        ptr_d         = idx_q;
                        state_d       = IDLE;
                    end else begin
                        gap_d   = '0;
                        state_d = GRANT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            ptr_q         <= PTR_RESET;
            count_q       <= '0;
            gap_q         <= '0;
            tx_data_q     <= '0;
            last_q        <= 1'b0;
            tx_write_q    <= 1'b0;
            burst_abort_q <= 1'b0;
            gap_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            gap_q         <= gap_d;
            tx_data_q     <= tx_data_d;
            last_q        <= last_d;
            tx_write_q    <= tx_write_d;
            burst_abort_q <= burst_abort_d;
            gap_timeout_q <= gap_timeout_d;
        end
    end

endmodule
